mtr_drv_multi: RTL and testbench



---
 rtl/mtr_pkg.sv | 15 +
 rtl/mtr_ch.sv | 160 ++++++++++++++++
 rtl/mtr_drv_multi.sv | 62 ++++++
 tb/tb_mtr_drv_multi.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/mtr_pkg.sv
// Shared types and helpers for the multi-channel motor PWM driver.
package mtr_pkg;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    RAMP_DN = 2'd1,
    DEAD    = 2'd2
  } mtr_state_t;

  // Width of a down-counter that must hold the value prd (at least one bit).
  function automatic int dead_w(input int prd);
    return (prd < 2) ? 1 : $clog2(prd + 1);
  endfunction

endpackage

// File: rtl/mtr_ch.sv
// One motor channel: slew-limited magnitude FSM with reversal dead interval,
// PWM compare against the shared counter, and registered H-bridge outputs.
module mtr_ch
  import mtr_pkg::*;
#(
  parameter int SPD_W     = 11,
  parameter int PWM_W     = 11,
  parameter int SLEW_STEP = 4,
  parameter int DEAD_PRD  = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_en,
  input  logic             i_prd_end,
  input  logic [PWM_W-1:0] i_cnt,
  input  logic [SPD_W-1:0] i_spd,
  input  logic             i_rev,
  output logic             o_frwrd,
  output logic             o_rev,
  output logic             o_settled
);

  localparam int             DW      = dead_w(DEAD_PRD);
  localparam int             MW      = SPD_W + 1;
  localparam logic [MW-1:0]  STEP    = MW'(SLEW_STEP);
  localparam logic [DW-1:0]  DEAD_LD = DW'(DEAD_PRD);

  mtr_state_t       r_state;
  mtr_state_t       w_state_nxt;
  logic [SPD_W-1:0] r_mag;
  logic [SPD_W-1:0] w_mag_nxt;
  logic             r_dir;
  logic             w_dir_nxt;
  logic [DW-1:0]    r_dead_cnt;
  logic [DW-1:0]    w_dead_nxt;
  logic             r_frwrd;
  logic             r_rev;
  logic             r_settled;
  logic             w_settled_nxt;

  logic [MW-1:0]    w_mag_x;
  logic [MW-1:0]    w_spd_x;
  logic [MW-1:0]    w_up_gap;
  logic [MW-1:0]    w_dn_gap;
  logic [MW-1:0]    w_up;
  logic [MW-1:0]    w_dn;
  logic [MW-1:0]    w_ramp_dn;
  logic [PWM_W-1:0] w_duty;
  logic             w_cmp;

  // Extra headroom bit keeps the step arithmetic from wrapping at either end.
  assign w_mag_x   = {1'b0, r_mag};
  assign w_spd_x   = {1'b0, i_spd};
  assign w_up_gap  = w_spd_x - w_mag_x;
  assign w_dn_gap  = w_mag_x - w_spd_x;
  assign w_up      = w_mag_x + ((w_up_gap < STEP) ? w_up_gap : STEP);
  assign w_dn      = w_mag_x - ((w_dn_gap < STEP) ? w_dn_gap : STEP);
  assign w_ramp_dn = w_mag_x - ((w_mag_x < STEP) ? w_mag_x : STEP);

  assign w_duty = PWM_W'(r_mag) << (PWM_W - SPD_W);
  assign w_cmp  = (i_cnt < w_duty);

  // Next FSM state, magnitude, direction and dead count for a period boundary.
  always_comb begin
    w_state_nxt = r_state;
    w_mag_nxt   = r_mag;
    w_dir_nxt   = r_dir;
    w_dead_nxt  = r_dead_cnt;
    case (r_state)
      RUN: begin
        if (i_rev == r_dir) begin
          if (w_spd_x > w_mag_x) begin
            w_mag_nxt = w_up[SPD_W-1:0];
          end else if (w_mag_x > w_spd_x) begin
            w_mag_nxt = w_dn[SPD_W-1:0];
          end else begin
            w_mag_nxt = r_mag;
          end
        end else if (r_mag == {SPD_W{1'b0}}) begin
          w_state_nxt = DEAD;
          w_dead_nxt  = DEAD_LD;
        end else begin
          w_mag_nxt = w_ramp_dn[SPD_W-1:0];
          if (w_ramp_dn == {MW{1'b0}}) begin
            w_state_nxt = DEAD;
            w_dead_nxt  = DEAD_LD;
          end else begin
            w_state_nxt = RAMP_DN;
          end
        end
      end
      RAMP_DN: begin
        if (i_rev == r_dir) begin
          w_state_nxt = RUN;
        end else begin
          w_mag_nxt = w_ramp_dn[SPD_W-1:0];
          if (w_ramp_dn == {MW{1'b0}}) begin
            w_state_nxt = DEAD;
            w_dead_nxt  = DEAD_LD;
          end else begin
            w_state_nxt = RAMP_DN;
          end
        end
      end
      DEAD: begin
        if (r_dead_cnt <= DW'(1)) begin
          w_state_nxt = RUN;
          w_dead_nxt  = {DW{1'b0}};
          w_dir_nxt   = i_rev;
          w_mag_nxt   = {SPD_W{1'b0}};
        end else begin
          w_dead_nxt = r_dead_cnt - DW'(1);
        end
      end
      default: begin
        w_state_nxt = RUN;
        w_mag_nxt   = {SPD_W{1'b0}};
        w_dir_nxt   = i_rev;
        w_dead_nxt  = {DW{1'b0}};
      end
    endcase
    w_settled_nxt = (w_state_nxt == RUN) && (w_dir_nxt == i_rev) && (w_mag_nxt == i_spd);
  end

  // Channel state and output registers; brake overrides the FSM on any cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= RUN;
      r_mag      <= {SPD_W{1'b0}};
      r_dir      <= 1'b0;
      r_dead_cnt <= {DW{1'b0}};
      r_frwrd    <= 1'b0;
      r_rev      <= 1'b0;
      r_settled  <= 1'b0;
    end else if (!i_en) begin
      r_state    <= RUN;
      r_mag      <= {SPD_W{1'b0}};
      r_dir      <= i_rev;
      r_dead_cnt <= {DW{1'b0}};
      r_frwrd    <= 1'b0;
      r_rev      <= 1'b0;
      r_settled  <= (i_spd == {SPD_W{1'b0}});
    end else begin
      if (i_prd_end) begin
        r_state    <= w_state_nxt;
        r_mag      <= w_mag_nxt;
        r_dir      <= w_dir_nxt;
        r_dead_cnt <= w_dead_nxt;
        r_settled  <= w_settled_nxt;
      end
      r_frwrd <= w_cmp && !r_dir && (r_state != DEAD);
      r_rev   <= w_cmp &&  r_dir && (r_state != DEAD);
    end
  end

  assign o_frwrd   = r_frwrd;
  assign o_rev     = r_rev;
  assign o_settled = r_settled;

endmodule

// File: rtl/mtr_drv_multi.sv
// N-channel motor PWM driver: one shared period counter feeding NUM_CH
// independent slew-limited channels.
module mtr_drv_multi
  import mtr_pkg::*;
#(
  parameter int NUM_CH    = 2,
  parameter int SPD_W     = 11,
  parameter int PWM_W     = 11,
  parameter int SLEW_STEP = 4,
  parameter int DEAD_PRD  = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic [NUM_CH*SPD_W-1:0] spd,
  input  logic [NUM_CH-1:0]       rev,
  output logic [NUM_CH-1:0]       PWM_frwrd,
  output logic [NUM_CH-1:0]       PWM_rev,
  output logic [NUM_CH-1:0]       settled,
  output logic                    prd_end
);

  logic [PWM_W-1:0] r_cnt;
  logic [PWM_W-1:0] w_cnt_nxt;
  logic             r_prd_end;

  assign w_cnt_nxt = r_cnt + PWM_W'(1);

  // Free-running period counter; prd_end is registered so it coincides with cnt == all-ones.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt     <= {PWM_W{1'b0}};
      r_prd_end <= 1'b0;
    end else begin
      r_cnt     <= w_cnt_nxt;
      r_prd_end <= (w_cnt_nxt == {PWM_W{1'b1}});
    end
  end

  assign prd_end = r_prd_end;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    mtr_ch #(
      .SPD_W     (SPD_W),
      .PWM_W     (PWM_W),
      .SLEW_STEP (SLEW_STEP),
      .DEAD_PRD  (DEAD_PRD)
    ) u_ch (
      .clk       (clk),
      .rst_n     (rst_n),
      .i_en      (en),
      .i_prd_end (r_prd_end),
      .i_cnt     (r_cnt),
      .i_spd     (spd[g*SPD_W +: SPD_W]),
      .i_rev     (rev[g]),
      .o_frwrd   (PWM_frwrd[g]),
      .o_rev     (PWM_rev[g]),
      .o_settled (settled[g])
    );
  end

endmodule

// File: tb/tb_mtr_drv_multi.sv
// Directed bench for mtr_drv_multi with 4-bit speed/PWM, slew 2, one dead period;
// counts high cycles of every output over each PWM period.
module tb_mtr_drv_multi;

  localparam int NCH = 4;
  localparam int W   = 4;

  logic              clk;
  logic              rst_n;
  logic              en;
  logic [NCH*W-1:0]  spd;
  logic [NCH-1:0]    rev;
  logic [NCH-1:0]    PWM_frwrd;
  logic [NCH-1:0]    PWM_rev;
  logic [NCH-1:0]    settled;
  logic              prd_end;

  int cmp_cnt;
  int err_cnt;
  int fcnt [NCH];
  int rcnt [NCH];
  int ovl;
  int pcnt;

  mtr_drv_multi #(
    .NUM_CH(NCH), .SPD_W(W), .PWM_W(W), .SLEW_STEP(2), .DEAD_PRD(1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .spd(spd), .rev(rev),
    .PWM_frwrd(PWM_frwrd), .PWM_rev(PWM_rev), .settled(settled), .prd_end(prd_end)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    cmp_cnt++;
    assert (obs === exp) else begin
      err_cnt++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic set_ch(input int ch, input int s, input logic r);
    logic [W-1:0] v;
    v = W'(s);
    spd[ch*W +: W] = v;
    rev[ch] = r;
  endtask

  // Wait for prd_end, then tally outputs over the following 16 cycles.
  task automatic run_period();
    int n;
    n = 0;
    while (prd_end !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("prd_end_seen", int'(prd_end), 1);
    for (int c = 0; c < NCH; c++) begin
      fcnt[c] = 0;
      rcnt[c] = 0;
    end
    ovl  = 0;
    pcnt = 0;
    @(posedge clk);
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      for (int c = 0; c < NCH; c++) begin
        fcnt[c] += int'(PWM_frwrd[c]);
        rcnt[c] += int'(PWM_rev[c]);
        if (PWM_frwrd[c] && PWM_rev[c]) ovl++;
      end
      pcnt += int'(prd_end);
    end
    chk("no_overlap", ovl, 0);
    chk("prd_end_once", pcnt, 1);
  endtask

  initial begin
    int exp2 [5];
    int sd [3];
    int su [3];
    int rf [7];
    int rr [7];
    exp2 = '{8, 10, 12, 14, 15};
    sd   = '{4, 2, 1};
    su   = '{3, 5, 6};
    rf   = '{4, 2, 0, 0, 0, 0, 0};
    rr   = '{0, 0, 0, 0, 2, 4, 6};
    cmp_cnt = 0;
    err_cnt = 0;
    rst_n = 1'b0;
    en    = 1'b0;
    spd   = '0;
    rev   = '0;
    set_ch(0, 6, 1'b0);
    set_ch(1, 3, 1'b1);
    set_ch(2, 15, 1'b0);
    set_ch(3, 0, 1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_frwrd", int'(PWM_frwrd), 0);
    chk("rst_rev", int'(PWM_rev), 0);
    chk("rst_settled", int'(settled), 0);
    chk("rst_prd_end", int'(prd_end), 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    en = 1'b1;

    // Ramp up on all channels
    run_period();
    chk("up1_ch0_f", fcnt[0], 2);
    chk("up1_ch0_r", rcnt[0], 0);
    chk("up1_ch1_r", rcnt[1], 2);
    chk("up1_ch1_f", fcnt[1], 0);
    chk("up1_ch2_f", fcnt[2], 2);
    chk("up1_ch3_f", fcnt[3], 0);
    chk("up1_settled", int'(settled), 8);
    run_period();
    chk("up2_ch0_f", fcnt[0], 4);
    chk("up2_ch1_r", rcnt[1], 3);
    chk("up2_ch2_f", fcnt[2], 4);
    chk("up2_settled", int'(settled), 10);
    run_period();
    chk("up3_ch0_f", fcnt[0], 6);
    chk("up3_ch2_f", fcnt[2], 6);
    chk("up3_settled", int'(settled), 11);
    for (int p = 0; p < 5; p++) begin
      run_period();
      chk("up_ch2_f", fcnt[2], exp2[p]);
      chk("hold_ch0_f", fcnt[0], 6);
      chk("hold_ch3_f", fcnt[3], 0);
    end
    chk("max_settled", int'(settled), 15);

    // Slew down without undershoot
    set_ch(0, 1, 1'b0);
    for (int p = 0; p < 3; p++) begin
      run_period();
      chk("sdn_ch0_f", fcnt[0], sd[p]);
      chk("sdn_ch0_r", rcnt[0], 0);
    end
    chk("sdn_settled0", int'(settled[0]), 1);
    set_ch(0, 6, 1'b0);
    for (int p = 0; p < 3; p++) begin
      run_period();
      chk("sup_ch0_f", fcnt[0], su[p]);
    end

    // Reversal with dead period
    set_ch(0, 6, 1'b1);
    for (int p = 0; p < 7; p++) begin
      run_period();
      chk("rvs_ch0_f", fcnt[0], rf[p]);
      chk("rvs_ch0_r", rcnt[0], rr[p]);
    end
    chk("rvs_settled0", int'(settled[0]), 1);

    // Abort a reversal mid-ramp
    set_ch(0, 6, 1'b0);
    run_period();
    chk("abt1_ch0_r", rcnt[0], 4);
    set_ch(0, 6, 1'b1);
    run_period();
    chk("abt2_ch0_r", rcnt[0], 4);
    chk("abt2_ch0_f", fcnt[0], 0);
    run_period();
    chk("abt3_ch0_r", rcnt[0], 6);

    // Brake mid-period
    set_ch(0, 8, 1'b1);
    run_period();
    chk("brk_ramp_r", rcnt[0], 8);
    repeat (5) @(negedge clk);
    chk("brk_pre_r", int'(PWM_rev[0]), 1);
    en = 1'b0;
    @(negedge clk);
    chk("brk_frwrd", int'(PWM_frwrd), 0);
    chk("brk_rev", int'(PWM_rev), 0);
    chk("brk_settled", int'(settled), 8);
    @(negedge clk);
    en = 1'b1;
    run_period();
    chk("rst1_ch0_r", rcnt[0], 2);
    chk("rst1_ch1_r", rcnt[1], 2);
    chk("rst1_ch2_f", fcnt[2], 2);
    run_period();
    chk("rst2_ch0_r", rcnt[0], 4);

    // Ramp to zero and stay low
    set_ch(0, 0, 1'b1);
    run_period();
    chk("zero1_ch0_r", rcnt[0], 2);
    run_period();
    chk("zero2_ch0_r", rcnt[0], 0);
    run_period();
    chk("zero3_ch0_r", rcnt[0], 0);
    chk("zero3_ch0_f", fcnt[0], 0);
    chk("zero_settled0", int'(settled[0]), 1);

    // Reset mid-period
    repeat (6) @(negedge clk);
    chk("mrst_pre_ch2", int'(PWM_frwrd[2]), 1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("mrst_frwrd", int'(PWM_frwrd), 0);
    chk("mrst_rev", int'(PWM_rev), 0);
    chk("mrst_settled", int'(settled), 0);
    chk("mrst_prd_end", int'(prd_end), 0);
    repeat (2) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule
